// File: rtl/id_ex_debug_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core, with load-use bubble insertion
// and a programmable multi-entry breakpoint unit driven by a RUN/HALT/STEP debug FSM.
module id_ex_debug_stage #(
    parameter int ADDR_W      = 32,
    parameter int CTRL_W      = 20,
    parameter int MEMREAD_BIT = 0,
    parameter int NUM_BP      = 4,
    parameter int BP_IDX_W    = 2,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         if_id_instruction,
    input  logic [ADDR_W-1:0]   if_id_pc_next,
    input  logic [CTRL_W-1:0]   ctrl_in,
    input  logic                flush_id,
    input  logic                bp_wr_en,
    input  logic [BP_IDX_W-1:0] bp_wr_idx,
    input  logic [ADDR_W-1:0]   bp_wr_addr,
    input  logic                bp_wr_valid,
    input  logic                continue_sig,
    input  logic                step_mode,
    output logic [4:0]          id_ex_rs,
    output logic [4:0]          id_ex_rt,
    output logic [4:0]          id_ex_rd,
    output logic [4:0]          id_ex_shamt,
    output logic [31:0]         id_ex_imm_sign_extended,
    output logic [ADDR_W-1:0]   id_ex_pc_next,
    output logic [CTRL_W-1:0]   id_ex_ctrl,
    output logic                stall,
    output logic                stall_breakpoint,
    output logic                halted,
    output logic [BP_IDX_W-1:0] bp_hit_idx,
    output logic [CNT_W-1:0]    bubble_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                skip, skip_nxt;
    logic                continue_sig_q;
    logic                cont_edge;
    logic [NUM_BP-1:0]   bp_valid;
    logic [ADDR_W-1:0]   bp_addr [NUM_BP];
    logic [ADDR_W-1:0]   id_pc;
    logic                bp_match;
    logic [BP_IDX_W-1:0] bp_first;
    logic                do_issue;
    logic                hit_load;
    logic                unused_opcode;

    assign unused_opcode = ^if_id_instruction[31:26];

    assign stall = id_ex_ctrl[MEMREAD_BIT] && (id_ex_rt != 5'd0) &&
                   ((id_ex_rt == if_id_instruction[25:21]) ||
                    (id_ex_rt == if_id_instruction[20:16]));

    assign cont_edge = continue_sig && !continue_sig_q;

    // Scan from the top down so the lowest matching entry wins.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        id_pc    = if_id_pc_next - ADDR_W'(4);
        bp_match = 1'b0;
        bp_first = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_valid[i] && (bp_addr[i] == id_pc)) begin
                bp_match = 1'b1;
                bp_first = BP_IDX_W'(i);
            end
        end
    end

    assign stall_breakpoint = (state == ST_HALT) ||
                              ((state == ST_RUN) && bp_match && !skip);

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip;
        do_issue  = 1'b0;
        hit_load  = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (flush_id || stall) begin
                    do_issue = 1'b0;
                end else if (bp_match && !skip) begin
                    state_nxt = ST_HALT;
                    hit_load  = 1'b1;
                end else begin
                    do_issue = 1'b1;
                    skip_nxt = 1'b0;
                end
            end
            ST_HALT: begin
                // Keep the reported entry current if the held instruction is a breakpoint.
                hit_load = bp_match;
                if (!flush_id && cont_edge) begin
                    skip_nxt  = 1'b1;
                    state_nxt = step_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_STEP: begin
                if (!flush_id && !stall) begin
                    do_issue  = 1'b1;
                    skip_nxt  = 1'b0;
                    state_nxt = ST_HALT;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_RUN;
            skip           <= 1'b0;
            continue_sig_q <= 1'b0;
            halted         <= 1'b0;
            bp_hit_idx     <= '0;
            bubble_count   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state          <= state_nxt;
            skip           <= skip_nxt;
            continue_sig_q <= continue_sig;
            halted         <= (state_nxt == ST_HALT);
            if (hit_load) begin
                bp_hit_idx <= bp_first;
            end
            if (!do_issue && (bubble_count != {CNT_W{1'b1}})) begin
                bubble_count <= bubble_count + CNT_W'(1);
            end
        end
    end

    // NOTE: the breakpoint table is small and must come up disabled, so it is reset like any flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_valid <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr[i] <= '0;
            end
        end else if (bp_wr_en) begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (bp_wr_idx == BP_IDX_W'(i)) begin
                    bp_valid[i] <= bp_wr_valid;
                    bp_addr[i]  <= bp_wr_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_rs                <= '0;
            id_ex_rt                <= '0;
            id_ex_rd                <= '0;
            id_ex_shamt             <= '0;
            id_ex_imm_sign_extended <= '0;
            id_ex_pc_next           <= '0;
            id_ex_ctrl              <= '0;
        end else if (do_issue) begin
            id_ex_rs                <= if_id_instruction[25:21];
            id_ex_rt                <= if_id_instruction[20:16];
            id_ex_rd                <= if_id_instruction[15:11];
            id_ex_shamt             <= if_id_instruction[10:6];
            id_ex_imm_sign_extended <= {{16{if_id_instruction[15]}}, if_id_instruction[15:0]};
            id_ex_pc_next           <= if_id_pc_next;
            id_ex_ctrl              <= ctrl_in;
        end else begin
            id_ex_rs                <= '0;
            id_ex_rt                <= '0;
            id_ex_rd                <= '0;
            id_ex_shamt             <= '0;
            id_ex_imm_sign_extended <= '0;
            id_ex_pc_next           <= '0;
            id_ex_ctrl              <= '0;
        end
    end

endmodule

// File: tb/tb_id_ex_debug_stage.sv
// Directed bench for id_ex_debug_stage: decode vectors plus hazard, breakpoint,
// step, priority, reset and counter-saturation sequences.
module tb_id_ex_debug_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] pc_next;
    logic [19:0] ctrl_in;
    logic        flush_id;
    logic        bp_wr_en;
    logic [1:0]  bp_wr_idx;
    logic [31:0] bp_wr_addr;
    logic        bp_wr_valid;
    logic        continue_sig;
    logic        step_mode;

    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm, pc_q;
    logic [19:0] ctrl_q;
    logic        stall, stall_bp, halted;
    logic [1:0]  hit_idx;
    logic [15:0] bcount;

    logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
    logic [31:0] s_imm, s_pc_q;
    logic [19:0] s_ctrl_q;
    logic        s_stall, s_stall_bp, s_halted;
    logic [1:0]  s_hit_idx;
    logic [3:0]  s_bcount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_debug_stage dut (
        .clk(clk), .rst_n(rst_n), .if_id_instruction(instr), .if_id_pc_next(pc_next),
        .ctrl_in(ctrl_in), .flush_id(flush_id), .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx),
        .bp_wr_addr(bp_wr_addr), .bp_wr_valid(bp_wr_valid), .continue_sig(continue_sig),
        .step_mode(step_mode), .id_ex_rs(rs), .id_ex_rt(rt), .id_ex_rd(rd),
        .id_ex_shamt(shamt), .id_ex_imm_sign_extended(imm), .id_ex_pc_next(pc_q),
        .id_ex_ctrl(ctrl_q), .stall(stall), .stall_breakpoint(stall_bp), .halted(halted),
        .bp_hit_idx(hit_idx), .bubble_count(bcount)
    );

    id_ex_debug_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .if_id_instruction(instr), .if_id_pc_next(pc_next),
        .ctrl_in(ctrl_in), .flush_id(flush_id), .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx),
        .bp_wr_addr(bp_wr_addr), .bp_wr_valid(bp_wr_valid), .continue_sig(continue_sig),
        .step_mode(step_mode), .id_ex_rs(s_rs), .id_ex_rt(s_rt), .id_ex_rd(s_rd),
        .id_ex_shamt(s_shamt), .id_ex_imm_sign_extended(s_imm), .id_ex_pc_next(s_pc_q),
        .id_ex_ctrl(s_ctrl_q), .stall(s_stall), .stall_breakpoint(s_stall_bp),
        .halted(s_halted), .bp_hit_idx(s_hit_idx), .bubble_count(s_bcount)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [19:0] ctrl;
        logic [4:0]  rs, rt, rd, sh;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] i, input logic [31:0] p, input logic [19:0] c);
        instr   = i;
        pc_next = p;
        ctrl_in = c;
    endtask

    task automatic bp_write(input logic [1:0] idx, input logic [31:0] addr, input logic v);
        bp_wr_en    = 1'b1;
        bp_wr_idx   = idx;
        bp_wr_addr  = addr;
        bp_wr_valid = v;
    endtask

    initial begin
        vecs[0] = '{32'h2008FFFC, 32'h14, 20'hABCD0, 5'd0, 5'd8,  5'd31, 5'd31, 32'hFFFFFFFC};
        vecs[1] = '{32'h012B5020, 32'h18, 20'h00000, 5'd9, 5'd11, 5'd10, 5'd0,  32'h00005020};
        vecs[2] = '{32'h000940C0, 32'h1C, 20'h55554, 5'd0, 5'd9,  5'd8,  5'd3,  32'h000040C0};
        vecs[3] = '{32'h8D2A8000, 32'h20, 20'hFFFFE, 5'd9, 5'd10, 5'd16, 5'd0,  32'hFFFF8000};

        rst_n = 1'b0;
        set_id(32'h0, 32'h0, 20'h0);
        flush_id = 1'b0; bp_wr_en = 1'b0; bp_wr_idx = 2'd0; bp_wr_addr = 32'h0;
        bp_wr_valid = 1'b0; continue_sig = 1'b0; step_mode = 1'b0;
        #12;
        check("reset_rt", rt, 0);
        check("reset_imm", imm, 0);
        check("reset_ctrl", ctrl_q, 0);
        check("reset_halted", halted, 0);
        check("reset_bcount", bcount, 0);
        rst_n = 1'b1;

        // Decode vectors
        for (int i = 0; i < 4; i++) begin
            set_id(vecs[i].instr, vecs[i].pc, vecs[i].ctrl);
            tick();
            check($sformatf("vec%0d_rs", i), rs, vecs[i].rs);
            check($sformatf("vec%0d_rt", i), rt, vecs[i].rt);
            check($sformatf("vec%0d_rd", i), rd, vecs[i].rd);
            check($sformatf("vec%0d_shamt", i), shamt, vecs[i].sh);
            check($sformatf("vec%0d_imm", i), imm, vecs[i].imm);
            check($sformatf("vec%0d_pc", i), pc_q, vecs[i].pc);
            check($sformatf("vec%0d_ctrl", i), ctrl_q, vecs[i].ctrl);
            check($sformatf("vec%0d_stall", i), stall, 0);
            check($sformatf("vec%0d_bcount", i), bcount, 0);
        end

        // Load-use hazard: lw $t1 then add $t2,$t1,$t3
        set_id(32'h8D090000, 32'h40, 20'h00001);
        tick();
        check("lw_rt", rt, 9);
        set_id(32'h012B5020, 32'h44, 20'h0);
        #1;
        check("lu_stall", stall, 1);
        tick();
        check("lu_bubble_rt", rt, 0);
        check("lu_bubble_ctrl", ctrl_q, 0);
        check("lu_bcount", bcount, 1);
        check("lu_stall_cleared", stall, 0);
        tick();
        check("lu_add_rs", rs, 9);
        check("lu_add_rt", rt, 11);
        check("lu_add_pc", pc_q, 32'h44);

        // Load into $zero must not stall
        set_id(32'h8D000000, 32'h48, 20'h00001);
        tick();
        set_id(32'h000B5020, 32'h4C, 20'h0);
        #1;
        check("lu0_stall", stall, 0);
        tick();
        check("lu0_rd", rd, 10);
        check("lu0_bcount", bcount, 1);

        // Breakpoint halt and resume
        set_id(32'h0, 32'h2C, 20'h0);
        bp_write(2'd2, 32'h30, 1'b1);
        tick();
        bp_wr_en = 1'b0;
        set_id(32'h20090005, 32'h34, 20'h0);
        #1;
        check("bp_stall_bp", stall_bp, 1);
        tick();
        check("bp_halted", halted, 1);
        check("bp_hit", hit_idx, 2);
        check("bp_rt", rt, 0);
        check("bp_bcount", bcount, 2);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) bp_write(2'd3, 32'h100, 1'b1);
            tick();
            bp_wr_en = 1'b0;
            check($sformatf("halt%0d_halted", k), halted, 1);
            check($sformatf("halt%0d_rt", k), rt, 0);
            check($sformatf("halt%0d_stall_bp", k), stall_bp, 1);
        end
        check("halt_bcount", bcount, 6);
        continue_sig = 1'b1;
        step_mode = 1'b0;
        tick();
        continue_sig = 1'b0;
        check("resume_halted", halted, 0);
        check("resume_bcount", bcount, 7);
        #1;
        check("resume_stall_bp", stall_bp, 0);
        tick();
        check("resume_rt", rt, 9);
        check("resume_imm", imm, 5);
        check("resume_bcount2", bcount, 7);
        set_id(32'h200A0007, 32'h38, 20'h0);
        tick();
        check("resume_next_rt", rt, 10);
        check("resume_next_halted", halted, 0);

        // Single step
        set_id(32'h20090005, 32'h34, 20'h0);
        tick();
        check("step_halted0", halted, 1);
        check("step_bcount0", bcount, 8);
        step_mode = 1'b1;
        continue_sig = 1'b1;
        tick();
        continue_sig = 1'b0;
        check("step_state_halted", halted, 0);
        check("step_bcount1", bcount, 9);
        #1;
        check("step_stall_bp", stall_bp, 0);
        tick();
        check("step_issue_rt", rt, 9);
        check("step_rehalt", halted, 1);
        check("step_bcount2", bcount, 9);
        set_id(32'h200A0007, 32'h38, 20'h0);
        #1;
        check("step_hold_stall_bp", stall_bp, 1);
        tick();
        check("step_hold_rt", rt, 0);
        check("step_hold_halted", halted, 1);
        check("step_hold_bcount", bcount, 10);
        check("step_hold_hit", hit_idx, 2);
        bp_write(2'd1, 32'h34, 1'b1);
        tick();
        bp_wr_en = 1'b0;
        check("wr_halt_hit_old", hit_idx, 2);
        check("wr_halt_halted", halted, 1);
        tick();
        check("wr_halt_hit_new", hit_idx, 1);
        check("wr_halt_bcount", bcount, 12);

        // Resume, then flush/hold priority
        step_mode = 1'b0;
        continue_sig = 1'b1;
        tick();
        continue_sig = 1'b0;
        tick();
        check("res2_rt", rt, 10);
        check("res2_halted", halted, 0);
        check("res2_bcount", bcount, 13);
        set_id(32'h20090005, 32'h34, 20'h0);
        flush_id = 1'b1;
        #1;
        check("flush_stall_bp", stall_bp, 1);
        tick();
        check("flush_run_halted", halted, 0);
        check("flush_run_rt", rt, 0);
        check("flush_run_bcount", bcount, 14);
        flush_id = 1'b0;
        tick();
        check("flush_then_halt", halted, 1);
        flush_id = 1'b1;
        tick();
        check("flush_halt_stays", halted, 1);
        check("flush_halt_bcount", bcount, 16);
        flush_id = 1'b0;

        // Async reset in HALT
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_halted", halted, 0);
        check("arst_bcount", bcount, 0);
        check("arst_hit", hit_idx, 0);
        check("arst_ctrl", ctrl_q, 0);
        check("arst_pc", pc_q, 0);
        check("arst_stall_bp", stall_bp, 0);
        #2;
        rst_n = 1'b1;
        tick();
        check("arst_issue_rt", rt, 9);
        check("arst_issue_halted", halted, 0);

        // Counter saturation (4-bit instance)
        flush_id = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (n == 13) check("sat_cnt14", s_bcount, 14);
        end
        flush_id = 1'b0;
        check("sat_cnt_final", s_bcount, 15);
        check("wide_cnt_final", bcount, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_debug_stage.md
Name: id_ex_debug_stage

Overview:
- Parametrised successor of the ID/EX pipeline register for the 5-stage MIPS core.
- Latches the decoded instruction fields and an externally decoded control bundle of generic width into the ID/EX register.
- Detects load-use hazards and inserts bubbles.
- Contains a multi-entry programmable breakpoint unit with a HALT/RUN/STEP debug state machine. This replaces the single hard-coded breakpoint and its asynchronous continue latch.

Parameters:
- ADDR_W, 32, width of PC and breakpoint addresses.
- CTRL_W, 20, width of the control bundle from the control unit.
- MEMREAD_BIT, 0, index in the control bundle of the mem_to_reg (load) bit.
- NUM_BP, 4, number of breakpoint entries (1..16).
- BP_IDX_W, 2, index width; must be at least clog2(NUM_BP), minimum 1.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_id_instruction  in  32  instruction in IF/ID.
- if_id_pc_next  in  ADDR_W  PC+4 of that instruction.
- ctrl_in  in  CTRL_W  decoded control bundle for if_id_instruction.
- flush_id  in  1  squash the ID instruction (branch/jump taken).
- bp_wr_en  in  1  write one breakpoint entry this cycle.
- bp_wr_idx  in  BP_IDX_W  entry to write.
- bp_wr_addr  in  ADDR_W  breakpoint instruction address.
- bp_wr_valid  in  1  valid bit to write (0 disables the entry).
- continue_sig  in  1  debug continue request, synchronous level; the rising edge is detected internally.
- step_mode  in  1  when 1, continue issues exactly one instruction and then re-halts.
- id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt  out  5 each  register fields.
- id_ex_imm_sign_extended  out  32  sign-extended instruction[15:0].
- id_ex_pc_next  out  ADDR_W  latched PC+4.
- id_ex_ctrl  out  CTRL_W  latched control bundle.
- stall  out  1  load-use stall request to IF/PC, combinational.
- stall_breakpoint  out  1  debug hold request to IF/PC, combinational.
- halted  out  1  registered; state is HALT.
- bp_hit_idx  out  BP_IDX_W  registered; lowest matching entry at the last halt.
- bubble_count  out  CNT_W  registered; saturating count of inserted bubbles.

Behaviour:
- Reset (async, rst_n=0):
  - All id_ex_* outputs are 0.
  - Breakpoint valid bits are 0; addresses are 0.
  - State is RUN; skip flag is 0; halted=0; bp_hit_idx=0; bubble_count=0; continue edge register is 0.
  - Reset mid-HALT or mid-STEP returns to RUN.
- Bubble: every id_ex_* output is loaded with 0.
- Issue: outputs load the fields of if_id_instruction:
  - rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6].
  - imm = {16{instr[15]}, instr[15:0]}.
  - pc_next=if_id_pc_next; ctrl=ctrl_in.
- Load-use hazard: stall = id_ex_ctrl[MEMREAD_BIT] & (id_ex_rt != 0) & (id_ex_rt==rs | id_ex_rt==rt).
- Breakpoint match: bp_match = OR over i of (valid[i] & addr[i] == if_id_pc_next - 4), computed modulo 2^ADDR_W.
- Breakpoint table write:
  - A write takes effect at the clock edge and is visible for matching in the next cycle.
  - A write during HALT does not release the halt.
- cont_edge = continue_sig & ~continue_sig_q.
- Per-edge priority: flush_id > stall > debug hold > issue.
- RUN state:
  - If bp_match & ~skip & ~flush_id & ~stall: bubble, go to HALT, latch bp_hit_idx as the lowest matching index.
  - Otherwise perform a normal issue, or a bubble when flush/stall is active.
  - Every normal issue clears skip.
- HALT state:
  - stall_breakpoint=1; bubble every cycle.
  - On cont_edge: set skip; go to STEP if step_mode=1, otherwise go to RUN.
  - flush_id in HALT produces a bubble and the state stays HALT.
- STEP state:
  - stall_breakpoint=0.
  - The first normal issue clears skip and returns to HALT on the same edge.
  - Flush and load-use bubbles do not count as the stepped instruction.
- stall_breakpoint (combinational) = (state==HALT) | (state==RUN & bp_match & ~skip).
- bubble_count:
  - Increments by 1 on every edge that loads a bubble (flush, stall, or debug).
  - Saturates at 2^CNT_W - 1.
- cont_edge outside HALT is ignored, and skip is unchanged.

Test Plan:
- Reset then plain issue:
  - Stimulus: instr 0x2008FFFC (addi $t0,$zero,-4), pc_next 0x14.
  - Required next cycle: rt=8, rs=0, imm=0xFFFFFFFC, pc_next=0x14, stall=0, bubble_count=0.
- Load-use:
  - Stimulus: lw $t1 issued (id_ex_rt=9, ctrl MEMREAD=1), then add $t2,$t1,$t3 in ID.
  - Required: stall=1, one bubble, bubble_count=1, add issues the following cycle.
  - Negative case: with id_ex_rt=0 the same sequence must give stall=0.
- Breakpoint halt and resume:
  - Stimulus: entry 2 = 0x30 valid; instruction with pc_next 0x34 in ID.
  - Required: halted=1, bp_hit_idx=2, bubbles for 5 cycles.
  - Stimulus: continue pulse with step_mode=0.
  - Required: the instruction at 0x30 issues exactly once and halted=0.
- Single step:
  - Stimulus: halted at 0x30 with step_mode=1, continue pulse.
  - Required: 0x30 issues; halted=1 again on the same edge.
  - Required: the next instruction 0x34 is held, unless it is also a breakpoint (then bp_hit_idx updates).
- Flush/hold priority:
  - Stimulus: flush_id=1 together with a bp_match.
  - Required: bubble, state stays RUN, halted=0.
  - Stimulus: flush_id=1 in HALT.
  - Required: stays HALT.
- Async reset mid-HALT and counter saturation:
  - Stimulus: rst_n low in HALT.
  - Required: halted=0 immediately; all outputs and the table valid bits are 0.
  - Stimulus: with CNT_W=4, 20 flushes.
  - Required: bubble_count=15.
